// File: rtl/sweep_ctrl.sv
// Sweeps the counter increment from a start value to a stop value in steps, holding each value for a dwell count.
// Optional SWEEP_BOUNCE_EN adds a RETURN leg that walks back to the start value before finishing.
module sweep_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   incr_start,
    input  logic [WIDTH-1:0]   incr_stop,
    input  logic [WIDTH-1:0]   incr_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [WIDTH-1:0]   incr,
    output logic               cnt_en,
    output logic               busy,
    output logic               done
);

`ifdef SWEEP_BOUNCE_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RETURN, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   incr_q, incr_d;
    logic               cnt_en_q, cnt_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   start_sh_q, start_sh_d;
    logic [WIDTH-1:0]   stop_sh_q, stop_sh_d;
    logic [WIDTH-1:0]   step_q, step_d;
    logic [DWELL_W-1:0] dwell_eff_q, dwell_eff_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic               up_q, up_d;
    logic               last_dwell;

    // One extra bit catches wrap above the top and borrow below zero; both clamp to tgt.
    function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt,
                                                     input logic [WIDTH-1:0] step,
                                                     input logic             up);
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   dif;
        logic [WIDTH-1:0] res;
        sum = {1'b0, cur} + {1'b0, step};
        dif = {1'b0, cur} - {1'b0, step};
        if (up)
            res = (sum > {1'b0, tgt}) ? tgt : sum[WIDTH-1:0];
        else
            res = (dif[WIDTH] || (dif[WIDTH-1:0] < tgt)) ? tgt : dif[WIDTH-1:0];
        return res;
    endfunction

    assign last_dwell = (dwell_cnt_q == (dwell_eff_q - 1'b1));

    always_comb begin
        state_d     = state_q;
        incr_d      = incr_q;
        cnt_en_d    = cnt_en_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_sh_d  = start_sh_q;
        stop_sh_d   = stop_sh_q;
        step_d      = step_q;
        dwell_eff_d = dwell_eff_q;
        dwell_cnt_d = dwell_cnt_q;
        up_d        = up_q;

        case (state_q)
            S_IDLE: begin
                incr_d   = '0;
                cnt_en_d = 1'b0;
                busy_d   = 1'b0;
                if (start && !abort) begin
                    start_sh_d  = incr_start;
                    stop_sh_d   = incr_stop;
                    step_d      = (incr_step == '0) ? WIDTH'(1) : incr_step;
                    dwell_eff_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                    up_d        = (incr_stop >= incr_start);
                    dwell_cnt_d = '0;
                    incr_d      = incr_start;
                    cnt_en_d    = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    incr_d   = '0;
                    cnt_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (last_dwell) begin
                    dwell_cnt_d = '0;
                    if (incr_q == stop_sh_q) begin
`ifdef SWEEP_BOUNCE_EN
                        if (stop_sh_q != start_sh_q) begin
                            state_d = S_RETURN;
                            incr_d  = step_toward(incr_q, start_sh_q, step_q, !up_q);
                        end else begin
                            state_d  = S_DONE;
                            done_d   = 1'b1;
                            incr_d   = '0;
                            cnt_en_d = 1'b0;
                            busy_d   = 1'b0;
                        end
`else
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        incr_d   = '0;
                        cnt_en_d = 1'b0;
                        busy_d   = 1'b0;
`endif
                    end else begin
                        incr_d = step_toward(incr_q, stop_sh_q, step_q, up_q);
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
`ifdef SWEEP_BOUNCE_EN
            S_RETURN: begin
                if (abort) begin
                    state_d  = S_IDLE;
                    incr_d   = '0;
                    cnt_en_d = 1'b0;
                    busy_d   = 1'b0;
                end else if (last_dwell) begin
                    dwell_cnt_d = '0;
                    if (incr_q == start_sh_q) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        incr_d   = '0;
                        cnt_en_d = 1'b0;
                        busy_d   = 1'b0;
                    end else begin
                        incr_d = step_toward(incr_q, start_sh_q, step_q, !up_q);
                    end
                end else begin
                    dwell_cnt_d = dwell_cnt_q + 1'b1;
                end
            end
`endif
            S_DONE: begin
                state_d  = S_IDLE;
                incr_d   = '0;
                cnt_en_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                incr_d   = '0;
                cnt_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            incr_q      <= '0;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_sh_q  <= '0;
            stop_sh_q   <= '0;
            step_q      <= '0;
            dwell_eff_q <= '0;
            dwell_cnt_q <= '0;
            up_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            incr_q      <= incr_d;
            cnt_en_q    <= cnt_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            start_sh_q  <= start_sh_d;
            stop_sh_q   <= stop_sh_d;
            step_q      <= step_d;
            dwell_eff_q <= dwell_eff_d;
            dwell_cnt_q <= dwell_cnt_d;
            up_q        <= up_d;
        end
    end

    assign incr   = incr_q;
    assign cnt_en = cnt_en_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Scoreboard bench for sweep_ctrl: a list-based sweep model queues per-cycle expectations, a monitor pops them.
module tb_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  incr_start = '0;
    logic [7:0]  incr_stop = '0;
    logic [7:0]  incr_step = '0;
    logic [15:0] dwell = '0;
    logic [7:0]  incr;
    logic        cnt_en;
    logic        busy;
    logic        done;

    typedef struct {
        logic [7:0] incr;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    sweep_ctrl #(.WIDTH(8), .DWELL_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .incr_start(incr_start), .incr_stop(incr_stop), .incr_step(incr_step), .dwell(dwell),
        .incr(incr), .cnt_en(cnt_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Expected sweep as a list of held values followed by the done cycle; only the first 'keep' entries are queued.
    function automatic void build(input int s, input int e, input int st, input int dw, input int keep);
        int   step;
        int   dwl;
        int   cur;
        exp_t t;
        exp_t lst[$];
        step = (st == 0) ? 1 : st;
        dwl  = (dw == 0) ? 1 : dw;
        cur  = s;
        t.done = 1'b0;
        t.incr = 8'(cur);
        for (int i = 0; i < dwl; i++) lst.push_back(t);
        while (cur != e) begin
            if (e >= s) cur = (cur + step > e) ? e : cur + step;
            else        cur = (cur - step < e) ? e : cur - step;
            t.incr = 8'(cur);
            for (int i = 0; i < dwl; i++) lst.push_back(t);
        end
`ifdef SWEEP_BOUNCE_EN
        while (cur != s) begin
            if (e >= s) cur = (cur - step < s) ? s : cur - step;
            else        cur = (cur + step > s) ? s : cur + step;
            t.incr = 8'(cur);
            for (int i = 0; i < dwl; i++) lst.push_back(t);
        end
`endif
        t.incr = 8'd0;
        t.done = 1'b1;
        lst.push_back(t);
        for (int i = 0; i < lst.size() && i < keep; i++) exp_q.push_back(lst[i]);
    endfunction

    always @(negedge clk) begin
        if (rst && (cnt_en || busy || done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: incr=%0d cnt_en=%0b busy=%0b done=%0b, required idle", incr, cnt_en, busy, done);
            end else begin
                mon_e = exp_q.pop_front();
                if (incr !== mon_e.incr || cnt_en !== !mon_e.done || busy !== !mon_e.done || done !== mon_e.done) begin
                    errors++;
                    $display("FAIL sweep_cycle: got incr=%0d cnt_en=%0b busy=%0b done=%0b, required incr=%0d cnt_en=%0b busy=%0b done=%0b",
                             incr, cnt_en, busy, done, mon_e.incr, !mon_e.done, !mon_e.done, mon_e.done);
                end else begin
                    $display("ok   incr=%0d done=%0b", incr, done);
                end
            end
        end
    end

    task automatic check_idle(input string name);
        checks++;
        if ({incr, cnt_en, busy, done} !== 11'd0) begin
            errors++;
            $display("FAIL %s: incr=%0d cnt_en=%0b busy=%0b done=%0b, required all 0", name, incr, cnt_en, busy, done);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            @(posedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected cycles never seen, required 0", name, exp_q.size());
        end
        exp_q.delete();
        check_idle({name, "_idle"});
        $display("sweep %s complete", name);
    endtask

    // Presents a launch; returns #1 into cycle 1 with the inputs scrambled so any re-latch shows up.
    task automatic launch(input int s, input int e, input int st, input int dw, input int keep);
        @(posedge clk);
        #1;
        incr_start = 8'(s);
        incr_stop  = 8'(e);
        incr_step  = 8'(st);
        dwell      = 16'(dw);
        start      = 1'b1;
        build(s, e, st, dw, keep);
        @(posedge clk);
        #1;
        start      = 1'b0;
        incr_start = 8'($urandom_range(0, 255));
        incr_stop  = 8'($urandom_range(0, 255));
        incr_step  = 8'($urandom_range(0, 255));
        dwell      = 16'($urandom_range(0, 7));
    endtask

    task automatic run(input string name, input int s, input int e, input int st, input int dw);
        launch(s, e, st, dw, 100000);
        drain(name, 5000);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check_idle("reset_state");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("post_reset_idle");

        run("basic_up",      10,  40, 10, 3);
        run("overshoot",      0,  25, 10, 1);
        run("no_wrap_top",  250, 255,  4, 1);
        run("down_dwell0",  200, 180,  7, 0);
        run("down_step0",   200, 180,  0, 1);
        run("single_value",   5,   5,  3, 2);
        run("bounce_case",   10,  30, 10, 2);
        run("no_wrap_zero",   6,   0,  4, 2);

        // Abort in cycle 5 after start pulses in cycles 1-4.
        launch(10, 40, 10, 3, 5);
        start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_idle("abort_idle");
        drain("abort", 20);

        // start and abort together in IDLE must not launch.
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        check_idle("start_with_abort");

        // Asynchronous reset between edges in cycle 7.
        launch(10, 40, 10, 3, 6);
        repeat (6) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_idle("async_reset");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL reset_prefix: %0d cycles unseen, required 0", exp_q.size());
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run("after_reset", 10, 40, 10, 3);

        // start held high relaunches after one IDLE cycle.
        @(posedge clk);
        #1;
        incr_start = 8'd5;
        incr_stop  = 8'd8;
        incr_step  = 8'd2;
        dwell      = 16'd1;
        start      = 1'b1;
        build(5, 8, 2, 1, 100000);
        build(5, 8, 2, 1, 100000);
        @(posedge clk);
        #1;
`ifdef SWEEP_BOUNCE_EN
        repeat (7) @(posedge clk);
`else
        repeat (5) @(posedge clk);
`endif
        #1;
        start = 1'b0;
        drain("start_held", 100);

        for (int n = 0; n < 25; n++) begin
            int s;
            int e;
            int st;
            int dw;
            s  = $urandom_range(0, 255);
            e  = $urandom_range(0, 255);
            st = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
            dw = $urandom_range(0, 3);
            $display("random sweep %0d: start=%0d stop=%0d step=%0d dwell=%0d", n, s, e, st, dw);
            run("random", s, e, st, dw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
